uart_rx: RTL and testbench

- Serial UART receiver; sits directly upstream of the UART controller/RX FIFO stage.
- Oversamples the asynchronous rx pin with the system clock and recovers 8N1 frames.
- Delivers each byte with a one-cycle done strobe and reports busy and frame-error status.
- The controller's byte-finish acknowledge releases a frame-error condition.

---
 rtl/uart_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling against a latched
// divisor, one-cycle done strobe, and a sticky frame error released by the controller.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int MIN_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          clk_div,
    input  logic                 i_rxd,
    input  logic                 i_ctrl_done,
    output logic [DATA_BITS-1:0] o_rx,
    output logic                 o_rx_done,
    output logic                 o_rx_busy,
    output logic                 o_frame_err
);

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        ERR
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 rxs_q, rxs_d;
    logic                 rxs_dly_q, rxs_dly_d;
    logic [31:0]          div_q, div_d;
    logic [31:0]          half_q, half_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_q, rx_d;
    logic                 rx_done_q, rx_done_d;
    logic                 busy_q, busy_d;
    logic                 frame_err_q, frame_err_d;
    logic                 ack_seen_q, ack_seen_d;
    logic [31:0]          div_sel;

    assign div_sel = (clk_div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : clk_div;

    always_comb begin
        state_d     = state_q;
        sync1_d     = i_rxd;
        rxs_d       = sync1_q;
        rxs_dly_d   = rxs_q;
        div_d       = div_q;
        half_d      = half_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rx_d        = rx_q;
        rx_done_d   = 1'b0;
        frame_err_d = frame_err_q;
        ack_seen_d  = ack_seen_q;

        case (state_q)
            IDLE: begin
                if (rxs_dly_q && !rxs_q) begin
                    div_d   = div_sel;
                    half_d  = div_sel >> 1;
                    cnt_d   = 32'd0;
                    state_d = START;
                end
            end
            START: begin
                // A start bit that is high again at its midpoint is treated as noise.
                if (cnt_q == half_q - 32'd1) begin
                    cnt_d = 32'd0;
                    if (!rxs_q) begin
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DATA: begin
                if (cnt_q == div_q - 32'd1) begin
                    shift_d[bit_q] = rxs_q;
                    cnt_d          = 32'd0;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            STOP: begin
                if (cnt_q == div_q - 32'd1) begin
                    cnt_d = 32'd0;
                    if (rxs_q) begin
                        rx_d      = shift_q;
                        rx_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ERR;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ERR: begin
                // Leave only once acknowledged and the line has returned to idle.
                ack_seen_d = ack_seen_q | i_ctrl_done;
                if (ack_seen_d && rxs_q) begin
                    frame_err_d = 1'b0;
                    ack_seen_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_dly_q   <= 1'b1;
            div_q       <= 32'd0;
            half_q      <= 32'd0;
            cnt_q       <= 32'd0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_q        <= '0;
            rx_done_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            ack_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rxs_q       <= rxs_d;
            rxs_dly_q   <= rxs_dly_d;
            div_q       <= div_d;
            half_q      <= half_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_q        <= rx_d;
            rx_done_q   <= rx_done_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            ack_seen_q  <= ack_seen_d;
        end
    end

    assign o_rx        = rx_q;
    assign o_rx_done   = rx_done_q;
    assign o_rx_busy   = busy_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit on i_rxd and every
// done strobe is logged by a negedge monitor for later comparison.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] clk_div;
    logic        i_rxd;
    logic        i_ctrl_done;
    logic [7:0]  o_rx;
    logic        o_rx_done;
    logic        o_rx_busy;
    logic        o_frame_err;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_count = 0;
    int          done_cyc = 0;
    int          double_done = 0;
    logic        prev_done = 1'b0;
    logic [7:0]  rx_log[$];
    logic [9:0]  busy_trace;
    int          base;
    int          start_cyc;
    int          latency;
    logic [7:0]  partial;

    uart_rx #(.DATA_BITS(8), .MIN_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_div     (clk_div),
        .i_rxd       (i_rxd),
        .i_ctrl_done (i_ctrl_done),
        .o_rx        (o_rx),
        .o_rx_done   (o_rx_done),
        .o_rx_busy   (o_rx_busy),
        .o_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every strobe and flag any strobe lasting more than one cycle.
    always @(negedge clk) begin
        if (o_rx_done) begin
            rx_log.push_back(o_rx);
            done_count++;
            done_cyc = cyc;
            if (prev_done) double_done++;
        end
        prev_done = o_rx_done;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start, LSB-first data and stop bits, each bc cycles long.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_val, input int bc);
        logic [9:0] bits;
        bits = {stop_val, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            i_rxd = bits[b];
            for (int c = 0; c < bc; c++) begin
                @(negedge clk);
                if (c == bc / 2) busy_trace[b] = o_rx_busy;
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        i_rxd       = 1'b1;
        clk_div     = 32'd8;
        i_ctrl_done = 1'b0;
        idle(3);
        @(negedge clk);
        checkOutput("reset_rx", 32'(o_rx), 32'h00);
        checkOutput("reset_done", 32'(o_rx_done), 32'h0);
        checkOutput("reset_busy", 32'(o_rx_busy), 32'h0);
        checkOutput("reset_err", 32'(o_frame_err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);

        $display("[TB] byte 0xA5 at div 8");
        base      = done_count;
        start_cyc = cyc;
        applyStimulus(8'hA5, 1'b1, 8);
        idle(4);
        checkOutput("a5_count", 32'(done_count), 32'(base + 1));
        checkOutput("a5_value", 32'(o_rx), 32'hA5);
        if (done_count > base) checkOutput("a5_logged", 32'(rx_log[base]), 32'hA5);
        latency = done_cyc - start_cyc;
        checkOutput("a5_latency_window", 32'(latency >= 73 && latency <= 83), 32'h1);
        checkOutput("a5_busy_trace", 32'(busy_trace), 32'h3FF);
        checkOutput("a5_err", 32'(o_frame_err), 32'h0);
        checkOutput("a5_busy_after", 32'(o_rx_busy), 32'h0);

        $display("[TB] start glitch at div 16");
        clk_div = 32'd16;
        idle(2);
        base  = done_count;
        i_rxd = 1'b0;
        idle(2);
        i_rxd = 1'b1;
        idle(2);
        checkOutput("glitch_busy_start", 32'(o_rx_busy), 32'h1);
        idle(10);
        checkOutput("glitch_busy_end", 32'(o_rx_busy), 32'h0);
        checkOutput("glitch_no_done", 32'(done_count), 32'(base));
        checkOutput("glitch_rx_hold", 32'(o_rx), 32'hA5);

        $display("[TB] frame error, ack with line high");
        clk_div = 32'd8;
        idle(2);
        base = done_count;
        applyStimulus(8'h3C, 1'b0, 8);
        i_rxd = 1'b1;
        idle(6);
        checkOutput("ferr_err", 32'(o_frame_err), 32'h1);
        checkOutput("ferr_busy", 32'(o_rx_busy), 32'h1);
        checkOutput("ferr_no_done", 32'(done_count), 32'(base));
        checkOutput("ferr_rx_hold", 32'(o_rx), 32'hA5);
        i_ctrl_done = 1'b1;
        @(negedge clk);
        checkOutput("ferr_err_before_ack", 32'(o_frame_err), 32'h1);
        @(posedge clk);
        #1;
        i_ctrl_done = 1'b0;
        @(negedge clk);
        checkOutput("ferr_err_cleared", 32'(o_frame_err), 32'h0);
        checkOutput("ferr_busy_cleared", 32'(o_rx_busy), 32'h0);
        @(posedge clk);
        #1;

        $display("[TB] frame error with break held through ack");
        applyStimulus(8'h3C, 1'b0, 8);
        idle(10);
        i_ctrl_done = 1'b1;
        idle(1);
        i_ctrl_done = 1'b0;
        idle(6);
        checkOutput("break_err_held", 32'(o_frame_err), 32'h1);
        checkOutput("break_busy_held", 32'(o_rx_busy), 32'h1);
        i_rxd = 1'b1;
        idle(5);
        checkOutput("break_err_released", 32'(o_frame_err), 32'h0);
        checkOutput("break_busy_released", 32'(o_rx_busy), 32'h0);

        base = done_count;
        applyStimulus(8'h3C, 1'b1, 8);
        idle(4);
        checkOutput("clean_3c_count", 32'(done_count), 32'(base + 1));
        checkOutput("clean_3c_value", 32'(o_rx), 32'h3C);

        $display("[TB] back-to-back frames at div 10");
        clk_div = 32'd10;
        idle(2);
        base = done_count;
        applyStimulus(8'h00, 1'b1, 10);
        applyStimulus(8'hFF, 1'b1, 10);
        applyStimulus(8'h55, 1'b1, 10);
        idle(6);
        checkOutput("b2b_count", 32'(done_count), 32'(base + 3));
        if (done_count >= base + 3) begin
            checkOutput("b2b_first", 32'(rx_log[base]), 32'h00);
            checkOutput("b2b_second", 32'(rx_log[base + 1]), 32'hFF);
            checkOutput("b2b_third", 32'(rx_log[base + 2]), 32'h55);
        end

        $display("[TB] reset in the middle of the data bits");
        clk_div = 32'd8;
        idle(2);
        base    = done_count;
        partial = 8'hB7;
        i_rxd   = 1'b0;
        idle(8);
        for (int b = 0; b < 4; b++) begin
            i_rxd = partial[b];
            idle(8);
        end
        i_rxd = partial[4];
        idle(4);
        rst   = 1'b1;
        i_rxd = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_rx", 32'(o_rx), 32'h00);
        checkOutput("mid_rst_done", 32'(o_rx_done), 32'h0);
        checkOutput("mid_rst_busy", 32'(o_rx_busy), 32'h0);
        checkOutput("mid_rst_err", 32'(o_frame_err), 32'h0);
        @(posedge clk);
        #1;
        idle(20);
        checkOutput("mid_rst_no_done", 32'(done_count), 32'(base));
        checkOutput("mid_rst_idle", 32'(o_rx_busy), 32'h0);
        applyStimulus(8'h81, 1'b1, 8);
        idle(4);
        checkOutput("post_rst_count", 32'(done_count), 32'(base + 1));
        checkOutput("post_rst_value", 32'(o_rx), 32'h81);

        $display("[TB] clk_div changed mid-frame, then clamped");
        base = done_count;
        fork
            applyStimulus(8'hC3, 1'b1, 8);
            begin
                idle(20);
                clk_div = 32'd32;
            end
        join
        idle(4);
        checkOutput("div_change_count", 32'(done_count), 32'(base + 1));
        checkOutput("div_change_value", 32'(o_rx), 32'hC3);
        clk_div = 32'd2;
        idle(2);
        applyStimulus(8'h5A, 1'b1, 4);
        idle(10);
        checkOutput("div_clamp_count", 32'(done_count), 32'(base + 2));
        checkOutput("div_clamp_value", 32'(o_rx), 32'h5A);
        checkOutput("div_clamp_err", 32'(o_frame_err), 32'h0);

        $display("[TB] acknowledge outside error state");
        i_ctrl_done = 1'b1;
        idle(1);
        i_ctrl_done = 1'b0;
        idle(2);
        checkOutput("stray_ack_busy", 32'(o_rx_busy), 32'h0);
        checkOutput("stray_ack_err", 32'(o_frame_err), 32'h0);

        checkOutput("done_single_cycle", 32'(double_done), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
